// File: rtl/alpha_blender_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alpha_blend_pkg : shared types and constants for alpha_blender      |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
package alpha_blend_pkg;

  localparam int NUM_PIXELS_DEFAULT = 76800;
  localparam int PIX_W              = 17;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    READ  = 3'd1,
    WAIT  = 3'd2,
    BLEND = 3'd3,
    WRITE = 3'd4,
    DROP  = 3'd5,
    DONE  = 3'd6
  } state_e;

endpackage
`default_nettype wire

// File: rtl/alpha_blender_blend_channel.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | blend_channel : combinational 8-bit src-over-dst mixer              |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module blend_channel (
  input  logic [7:0] src,
  input  logic [7:0] dst,
  input  logic [7:0] alpha,
  output logic [7:0] mix
);

  logic [8:0]  a9;
  logic [8:0]  inv9;
  logic [16:0] sum;

  always_comb begin
    // Folding the top bit back in maps 255 to 256, so opaque returns src exactly.
    a9   = {1'b0, alpha} + {8'd0, alpha[7]};
    inv9 = 9'd256 - a9;
    sum  = ({9'd0, src} * {8'd0, a9}) + ({9'd0, dst} * {8'd0, inv9});
    mix  = 8'(sum >> 8);
  end

endmodule
`default_nettype wire

// File: rtl/alpha_blender.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | alpha_blender : read-modify-write alpha blend into the frame buffer |
// | Optional macro ALPHA_OPAQUE_SKIP_EN: opaque pixels bypass the read. |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module alpha_blender
  import alpha_blend_pkg::*;
#(
  parameter int RD_LAT     = 2,
  parameter int NUM_PIXELS = NUM_PIXELS_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic [7:0]       in_r,
  input  logic [7:0]       in_g,
  input  logic [7:0]       in_b,
  input  logic [7:0]       in_alpha,
  input  logic             in_last,
  output logic             read,
  output logic             write,
  output logic [PIX_W-1:0] Pixel_Number,
  input  logic [7:0]       read_r,
  input  logic [7:0]       read_g,
  input  logic [7:0]       read_b,
  output logic [7:0]       write_r,
  output logic [7:0]       write_g,
  output logic [7:0]       write_b,
  output logic             frame_ready,
  output logic             busy
);

  localparam int                CNT_W     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(RD_LAT - 1);
  localparam logic [PIX_W:0]    PIX_LIMIT = (PIX_W + 1)'(NUM_PIXELS);

  state_e                state_q, state_d;
  logic [PIX_W-1:0]      pix_q, pix_d;
  logic [PIX_W-1:0]      addr_q, addr_d;
  logic [2:0][7:0]       src_q, src_d;
  logic [2:0][7:0]       dst_q, dst_d;
  logic [2:0][7:0]       wr_q, wr_d;
  logic [7:0]            alpha_q, alpha_d;
  logic                  last_q, last_d;
  logic                  rdy_q, rdy_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic [2:0][7:0]       in_rgb;
  logic [2:0][7:0]       rd_rgb;
  logic [2:0][7:0]       mix;
  logic                  xfer;

  assign in_rgb = {in_r, in_g, in_b};
  assign rd_rgb = {read_r, read_g, read_b};
  assign xfer   = in_valid && rdy_q;

  generate
    for (genvar i = 0; i < 3; i++) begin : g_ch
      blend_channel u_mix (
        .src   (src_q[i]),
        .dst   (dst_q[i]),
        .alpha (alpha_q),
        .mix   (mix[i])
      );
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    pix_d   = pix_q;
    addr_d  = addr_q;
    src_d   = src_q;
    dst_d   = dst_q;
    wr_d    = wr_q;
    alpha_d = alpha_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (xfer) begin
          pix_d   = in_pixel;
          src_d   = in_rgb;
          alpha_d = in_alpha;
          last_d  = in_last;
          if ({1'b0, in_pixel} >= PIX_LIMIT) begin
            state_d = DROP;
`ifdef ALPHA_OPAQUE_SKIP_EN
          end else if (in_alpha == 8'hFF) begin
            state_d = WRITE;
            wr_d    = in_rgb;
            addr_d  = in_pixel;
`endif
          end else begin
            state_d = READ;
            addr_d  = in_pixel;
          end
        end
      end
      READ: begin
        state_d = WAIT;
        cnt_d   = '0;
      end
      WAIT: begin
        // Read data is only guaranteed on the last counted cycle.
        if (cnt_q == CNT_LAST) begin
          dst_d   = rd_rgb;
          state_d = BLEND;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      BLEND: begin
        wr_d    = mix;
        addr_d  = pix_q;
        state_d = WRITE;
      end
      WRITE:   state_d = last_q ? DONE : IDLE;
      DROP:    state_d = last_q ? DONE : IDLE;
      DONE:    state_d = DONE;
      default: state_d = IDLE;
    endcase
    rdy_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pix_q   <= '0;
      addr_q  <= '0;
      src_q   <= '0;
      dst_q   <= '0;
      wr_q    <= '0;
      alpha_q <= '0;
      last_q  <= 1'b0;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pix_q   <= pix_d;
      addr_q  <= addr_d;
      src_q   <= src_d;
      dst_q   <= dst_d;
      wr_q    <= wr_d;
      alpha_q <= alpha_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign in_ready     = rdy_q;
  assign read         = (state_q == READ);
  assign write        = (state_q == WRITE);
  assign Pixel_Number = addr_q;
  assign write_r      = wr_q[2];
  assign write_g      = wr_q[1];
  assign write_b      = wr_q[0];
  assign frame_ready  = (state_q == DONE);
  assign busy         = (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_alpha_blender.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_alpha_blender : self-checking bench for alpha_blender            |
// | Rev 1.0                                                             |
// +--------------------------------------------------------------------+
module tb_alpha_blender;
  import alpha_blend_pkg::*;

  localparam int RD_LAT = 2;
  localparam int NPIX   = NUM_PIXELS_DEFAULT;
`ifdef ALPHA_OPAQUE_SKIP_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_last;
  logic [16:0] in_pixel;
  logic [7:0]  in_r, in_g, in_b, in_alpha;
  logic        read, write, frame_ready, busy;
  logic [16:0] Pixel_Number;
  logic [7:0]  read_r, read_g, read_b;
  logic [7:0]  write_r, write_g, write_b;

  always #5 clk = ~clk;

  alpha_blender #(.RD_LAT(RD_LAT), .NUM_PIXELS(NPIX)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_pixel(in_pixel),
    .in_r(in_r), .in_g(in_g), .in_b(in_b), .in_alpha(in_alpha), .in_last(in_last),
    .read(read), .write(write), .Pixel_Number(Pixel_Number),
    .read_r(read_r), .read_g(read_g), .read_b(read_b),
    .write_r(write_r), .write_g(write_g), .write_b(write_b),
    .frame_ready(frame_ready), .busy(busy)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int n_writes = 0;
  bit mon_en   = 1'b0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Frame-buffer model: fixed read latency, garbage on the bus otherwise.
  logic [23:0] fb [0:NPIX-1];
  bit          pv [0:RD_LAT-2];
  logic [16:0] pa [0:RD_LAT-2];
  logic        preset_en = 1'b0;
  logic [16:0] preset_addr;
  logic [23:0] preset_val;

  always @(posedge clk) begin
    if (preset_en) fb[preset_addr] <= preset_val;
    if (write && int'(Pixel_Number) < NPIX) fb[Pixel_Number] <= {write_r, write_g, write_b};
    pv[0] <= read;
    pa[0] <= Pixel_Number;
    for (int i = 1; i < RD_LAT - 1; i++) begin
      pv[i] <= pv[i-1];
      pa[i] <= pa[i-1];
    end
    if (pv[RD_LAT-2]) {read_r, read_g, read_b} <= fb[pa[RD_LAT-2]];
    else              {read_r, read_g, read_b} <= 24'hA55AC3;
  end

  // Scoreboard: expectations are pushed at transfer, popped on each strobe.
  typedef struct { int addr; int rgb; int t; } exp_t;
  exp_t rdq[$];
  exp_t wrq[$];
  exp_t me;

  always @(negedge clk) begin
    if (mon_en) begin
      if (read && write) chk("rd_wr_exclusive", 1, 0);
      if (read) begin
        if (rdq.size() == 0) chk("unexpected_read", int'(Pixel_Number), -1);
        else begin
          me = rdq.pop_front();
          chk("read_addr", int'(Pixel_Number), me.addr);
          chk("read_time", cyc + 1, me.t);
        end
      end
      if (write) begin
        n_writes++;
        if (wrq.size() == 0) chk("unexpected_write", int'(Pixel_Number), -1);
        else begin
          me = wrq.pop_front();
          chk("write_addr", int'(Pixel_Number), me.addr);
          chk("write_rgb", int'({write_r, write_g, write_b}), me.rgb);
          chk("write_time", cyc + 1, me.t);
        end
      end
    end
  end

  task automatic preset(input int pix, input logic [23:0] val);
    preset_en   = 1'b1;
    preset_addr = 17'(pix);
    preset_val  = val;
    @(negedge clk);
    preset_en   = 1'b0;
  endtask

  // Called at a negedge; returns the transfer edge number in t.
  task automatic send(input int pix, input logic [23:0] rgb, input logic [7:0] a,
                      input bit last, output int t);
    in_valid = 1'b1;
    in_pixel = 17'(pix);
    {in_r, in_g, in_b} = rgb;
    in_alpha = a;
    in_last  = last;
    t = -1;
    for (int k = 0; k < 50; k++) begin
      if (in_ready) begin
        t = cyc + 1;
        break;
      end
      @(negedge clk);
    end
    if (t < 0) chk("send_timeout", 0, 1);
  endtask

  task automatic expect_px(input int pix, input logic [23:0] exp, input logic [7:0] a, input int t);
    if (pix >= NPIX) return;
    if (SKIP && a == 8'hFF) wrq.push_back('{pix, int'(exp), t + 1});
    else begin
      rdq.push_back('{pix, 0, t + 1});
      wrq.push_back('{pix, int'(exp), t + RD_LAT + 3});
    end
  endtask

  task automatic wait_idle(input string name);
    for (int k = 0; k < 60; k++) begin
      @(negedge clk);
      if (rdq.size() == 0 && wrq.size() == 0 && in_ready) return;
    end
    chk(name, 0, 1);
  endtask

  task automatic chk_all_zero(input string name);
    chk({name, "_read"}, int'(read), 0);
    chk({name, "_write"}, int'(write), 0);
    chk({name, "_frame_ready"}, int'(frame_ready), 0);
    chk({name, "_busy"}, int'(busy), 0);
    chk({name, "_in_ready"}, int'(in_ready), 0);
    chk({name, "_pixnum"}, int'(Pixel_Number), 0);
    chk({name, "_wr_rgb"}, int'({write_r, write_g, write_b}), 0);
  endtask

  typedef struct {
    int          pix;
    logic [23:0] src;
    logic [7:0]  alpha;
    logic [23:0] dst;
    logic [23:0] exp;
  } vec_t;
  vec_t vecs [7];

  initial begin
    int t, t1, t2, t3, w0, bad;
    vecs[0] = '{5,      24'hC8C8C8, 8'd128, 24'h646464, 24'h969696};
    vecs[1] = '{42,     24'h070809, 8'd255, 24'h000000, 24'h070809};
    vecs[2] = '{7,      24'hFFFFFF, 8'd0,   24'h0A141E, 24'h0A141E};
    vecs[3] = '{76800,  24'h112233, 8'd90,  24'h000000, 24'h000000};
    vecs[4] = '{76799,  24'h000000, 8'd64,  24'hC86432, 24'h964B25};
    vecs[5] = '{0,      24'hFF0080, 8'd127, 24'h00FF80, 24'h7E8080};
    vecs[6] = '{131071, 24'h445566, 8'd200, 24'h000000, 24'h000000};

    rst = 1'b1; in_valid = 1'b0; in_pixel = '0; in_last = 1'b0;
    in_r = '0; in_g = '0; in_b = '0; in_alpha = '0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    mon_en = 1'b1;
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_reset", int'(in_ready), 1);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].pix < NPIX) preset(vecs[i].pix, vecs[i].dst);
      send(vecs[i].pix, vecs[i].src, vecs[i].alpha, 1'b0, t);
      expect_px(vecs[i].pix, vecs[i].exp, vecs[i].alpha, t);
      @(negedge clk);
      in_valid = 1'b0;
      if (vecs[i].pix >= NPIX) begin
        chk("drop_not_ready", int'(in_ready), 0);
        @(negedge clk);
        chk("drop_ready_back", int'(in_ready), 1);
      end else begin
        wait_idle("pixel_timeout");
      end
    end

    // Reset in the cycle after the read strobe must abort the pixel.
    preset(20, 24'h101010);
    send(20, 24'hC8C8C8, 8'd128, 1'b0, t);
    expect_px(20, 24'h000000, 8'd128, t);
    @(negedge clk);
    in_valid = 1'b0;
    chk("abort_read_seen", int'(read), 1);
    w0 = n_writes;
    @(negedge clk);
    rst = 1'b1;
    wrq.delete();
    @(negedge clk);
    chk_all_zero("abort");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("abort_ready_low", int'(in_ready), 0);
    @(negedge clk);
    chk("abort_ready_back", int'(in_ready), 1);
    repeat (8) @(negedge clk);
    chk("abort_no_write", n_writes, w0);

    // Back-to-back frame tail with in_valid held high.
    preset(10, 24'h000000);
    preset(11, 24'h010203);
    preset(12, 24'h0064FF);
    send(10, 24'h323C46, 8'd254, 1'b0, t1);
    expect_px(10, 24'h313B45, 8'd254, t1);
    @(negedge clk);
    send(11, 24'h090909, 8'd0, 1'b0, t2);
    expect_px(11, 24'h010203, 8'd0, t2);
    @(negedge clk);
    send(12, 24'h6400FF, 8'd200, 1'b1, t3);
    expect_px(12, 24'h4E15FF, 8'd200, t3);
    chk("b2b_gap_1", t2 - t1, RD_LAT + 4);
    chk("b2b_gap_2", t3 - t2, RD_LAT + 4);
    chk("frame_ready_early", int'(frame_ready), 0);
    for (int k = 0; k < 40 && wrq.size() != 0; k++) @(negedge clk);
    chk("frame_writes_drained", wrq.size(), 0);
    @(negedge clk);
    chk("frame_ready_set", int'(frame_ready), 1);
    chk("done_busy", int'(busy), 1);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready || !frame_ready) bad++;
    end
    chk("done_hold_100", bad, 0);
    in_valid = 1'b0;

    chk("rdq_drained", rdq.size(), 0);
    chk("wrq_drained", wrq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
